// File: rtl/queue_drain_stage_pkg.sv
// Shared definitions for the queue drain stage: FSM state encoding and
// entry field slicing helpers for the M/N split.
package queue_drain_stage_pkg;
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;
endpackage

`define QDS_M_FIELD(e, nw, mw) e[(nw)+(mw)-1:(nw)]
`define QDS_N_FIELD(e, nw) e[(nw)-1:0]

// File: rtl/queue_drain_stage_sat_countern.sv
// Saturating up-counter with asynchronous active-high clear; holds at all-ones.
module sat_countern #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr) count <= '0;
    else if (inc && (count != {WIDTH{1'b1}})) count <= count + 1'b1;
  end
endmodule

// File: rtl/queue_drain_stage.sv
// Pops READY head entries from the M/N queue into a 2-entry skid buffer feeding
// a valid/ready output; flush mode discards queued entries and counts them.
module queue_drain_stage
  import queue_drain_stage_pkg::*;
#(
  parameter int M_WIDTH   = 8,
  parameter int N_WIDTH   = 8,
  parameter int READY_BIT = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [M_WIDTH+N_WIDTH-1:0] q_dout,
  input  logic                       q_empty,
  output logic                       q_rd,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [M_WIDTH+N_WIDTH-1:0] out_data,
  output logic                       flushing,
  output logic [CNT_WIDTH-1:0]       stall_cnt,
  output logic [CNT_WIDTH-1:0]       drop_cnt
);
  localparam int E_WIDTH = M_WIDTH + N_WIDTH;

  state_t state, state_nxt;
  logic [1:0]         count;
  logic [1:0]         slot;
  logic [E_WIDTH-1:0] buf0, buf1;
  logic               head_rdy, push, pop;

  assign head_rdy = q_dout[N_WIDTH+READY_BIT];

  // q_rd depends on registered count only, never on out_ready (timing cut)
  always_comb begin
    state_nxt = state;
    q_rd      = 1'b0;
    unique case (state)
      ST_RUN: begin
        q_rd = ~clr & ~q_empty & head_rdy & (count < 2'd2) & ~flush;
        if (flush) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        q_rd = ~clr & ~q_empty;
        if (!flush && q_empty) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  assign flushing  = (state == ST_FLUSH);
  assign out_valid = (count != 2'd0);
  assign out_data  = buf0;
  assign push      = q_rd & (state == ST_RUN);
  assign pop       = out_valid & out_ready;
  assign slot      = count - {1'b0, pop};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= ST_RUN;
      count <= 2'd0;
      buf0  <= '0;
      buf1  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        count <= 2'd0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, pop};
        if (pop) buf0 <= buf1;
        // push lands in the first free slot after the pop shift
        if (push) begin
          if (slot == 2'd0) buf0 <= q_dout;
          else              buf1 <= q_dout;
        end
      end
    end
  end

  sat_countern #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   ((state == ST_RUN) & ~q_empty & ~head_rdy),
    .count (stall_cnt)
  );

  sat_countern #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .clr   (clr),
    .inc   ((state == ST_FLUSH) & q_rd),
    .count (drop_cnt)
  );
endmodule

// File: tb/tb_queue_drain_stage.sv
// Bench for queue_drain_stage: queue-level reference model, directed steps then random traffic.
module tb_queue_drain_stage;
  localparam int MW = 8, NW = 8, RB = 0, CW = 4, EW = MW + NW;
  localparam logic [CW-1:0] SAT = {CW{1'b1}};

  logic clk = 1'b0, clr = 1'b1, q_empty = 1'b1, flush = 1'b0, out_ready = 1'b0;
  logic [EW-1:0] q_dout = '0;
  logic q_rd, out_valid, flushing;
  logic [EW-1:0] out_data;
  logic [CW-1:0] stall_cnt, drop_cnt;

  queue_drain_stage #(.M_WIDTH(MW), .N_WIDTH(NW), .READY_BIT(RB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .clr(clr), .q_dout(q_dout), .q_empty(q_empty), .q_rd(q_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flushing(flushing),
    .stall_cnt(stall_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [EW-1:0] envq[$];     // upstream queue contents, head at [0]
  logic [EW-1:0] mbuf[$];     // expected buffered entries, oldest at [0]
  bit  m_flush = 0;
  int  m_stall = 0, m_drop = 0;
  int  qrd_cnt = 0, ov_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input bit rdy, input logic [7:0] tagv);
    logic [MW-1:0] m;
    m = MW'($urandom);
    m[RB] = rdy;
    return {m, tagv};
  endfunction

  function automatic bit head_ready();
    logic [EW-1:0] h;
    if (envq.size() == 0) return 0;
    h = envq[0];
    return h[NW+RB];
  endfunction

  task automatic model_reset();
    mbuf.delete();
    m_flush = 0; m_stall = 0; m_drop = 0;
  endtask

  // one cycle: present head, check outputs mid-cycle, advance model, cross the edge
  task automatic step();
    bit exp_qrd, nonempty;
    nonempty = (envq.size() != 0);
    q_empty = !nonempty;
    q_dout  = nonempty ? envq[0] : '0;
    #4;
    if (m_flush) exp_qrd = nonempty;
    else         exp_qrd = nonempty && head_ready() && (mbuf.size() < 2) && !flush;
    chk("q_rd", q_rd, exp_qrd);
    chk("out_valid", out_valid, (!m_flush && mbuf.size() != 0));
    if (!m_flush && mbuf.size() != 0) chk("out_data", out_data, mbuf[0]);
    chk("flushing", flushing, m_flush);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("drop_cnt", drop_cnt, m_drop);
    if (q_rd) qrd_cnt++;
    if (out_valid) ov_cnt++;
    if (!m_flush) begin
      if (nonempty && !head_ready() && m_stall < int'(SAT)) m_stall++;
      if (flush) begin
        mbuf.delete();
        m_flush = 1;
      end else begin
        if (mbuf.size() != 0 && out_ready) void'(mbuf.pop_front());
        if (exp_qrd) mbuf.push_back(envq[0]);
      end
    end else begin
      if (exp_qrd && m_drop < int'(SAT)) m_drop++;
      if (!flush && !nonempty) m_flush = 0;
    end
    if (exp_qrd) void'(envq.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [EW-1:0] h;
    int s0;
    // reset values
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q_rd", q_rd, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_stall", stall_cnt, 0);
    @(posedge clk); #1;
    clr = 0;
    model_reset();

    // streaming: 4 READY heads back-to-back
    out_ready = 1;
    for (int i = 0; i < 4; i++) envq.push_back(mk(1, 8'h10 + 8'(i)));
    qrd_cnt = 0; ov_cnt = 0;
    steps(6);
    chk("stream_qrd_cycles", qrd_cnt, 4);
    chk("stream_valid_cycles", ov_cnt, 4);

    // backpressure: exactly 2 pops then stop
    out_ready = 0;
    for (int i = 0; i < 3; i++) envq.push_back(mk(1, 8'h20 + 8'(i)));
    qrd_cnt = 0;
    steps(4);
    chk("bp_pops", qrd_cnt, 2);
    chk("bp_qrd_blocked", q_rd, 0);
    chk("bp_left_in_queue", envq.size(), 1);
    out_ready = 1;
    steps(5);
    chk("bp_drained", envq.size(), 0);

    // not-ready head for 5 cycles then READY
    s0 = m_stall;
    envq.push_back(mk(0, 8'h30));
    qrd_cnt = 0;
    steps(5);
    chk("stall_5", stall_cnt, 5);
    h = envq[0]; h[NW+RB] = 1'b1; envq[0] = h;
    steps(3);
    chk("stall_single_pop", qrd_cnt, 1);
    chk("stall_held", stall_cnt, s0 + 5);

    // flush with full buffer and 3 queued non-ready entries
    out_ready = 0;
    envq.push_back(mk(1, 8'h40));
    envq.push_back(mk(1, 8'h41));
    steps(3);
    for (int i = 0; i < 3; i++) envq.push_back(mk(0, 8'h50 + 8'(i)));
    s0 = m_stall;
    flush = 1;
    step();
    flush = 0;
    chk("flush_valid_low", out_valid, 0);
    chk("flush_state", flushing, 1);
    qrd_cnt = 0;
    steps(5);
    chk("flush_drops", drop_cnt, 3);
    chk("flush_qrd_cycles", qrd_cnt, 3);
    chk("flush_back_run", flushing, 0);

    // saturation of stall counter
    envq.push_back(mk(0, 8'h60));
    steps(20);
    chk("stall_sat", stall_cnt, SAT);
    steps(2);
    chk("stall_sat_hold", stall_cnt, SAT);
    envq.delete();

    // reset mid-stream
    out_ready = 0;
    for (int i = 0; i < 3; i++) envq.push_back(mk(1, 8'h70 + 8'(i)));
    steps(2);
    #3 clr = 1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_qrd", q_rd, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    chk("mid_rst_flushing", flushing, 0);
    @(posedge clk); #1;
    clr = 0;
    model_reset();
    h = envq[0]; h[NW+RB] = 1'b0; envq[0] = h;
    steps(2);
    h = envq[0]; h[NW+RB] = 1'b1; envq[0] = h;
    out_ready = 1;
    steps(4);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && envq.size() < 6) envq.push_back(mk($urandom_range(0, 3) != 0, 8'($urandom)));
      if (envq.size() != 0 && $urandom_range(0, 4) == 0) begin
        h = envq[0]; h[NW+RB] = 1'b1; envq[0] = h;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
